// File: rtl/wb_write_queue.sv
// wb_write_queue: register-file writeback queue.
// Merges load (mem) and ALU writeback requests into a circular FIFO and
// drains one entry per cycle into the register file unless rf_stall is high.
// Load writebacks have priority for the last free slot. When both ports
// handshake in the same cycle, the load entry is enqueued first.
// Writes to r0 are accepted and then dropped.
// Optional feature: define WB_BYPASS_EN to add query_data. It returns the
// youngest queued value for query_reg.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_reg,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [3:0]  alu_reg,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        rf_stall,
    output logic        write_reg,
    output logic [3:0]  dst_reg,
    output logic [15:0] dst_data,
    input  logic [3:0]  query_reg,
    output logic        query_hit,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
`ifdef WB_BYPASS_EN
    ,
    output logic [15:0] query_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;

    logic [3:0]  reg_mem  [DEPTH];
    logic [15:0] data_mem [DEPTH];

    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    logic [3:0] count_q, count_d;

    logic [3:0] free;
    logic       mem_push;
    logic       alu_push;
    logic       pop;
    ptr_t       alu_wptr;

    // Readiness is based on current occupancy only. A same-cycle pop does not
    // create a free slot.
    assign free      = 4'(DEPTH) - count_q;
    assign empty     = (count_q == 4'd0);
    assign full      = (count_q == 4'(DEPTH));
    assign count     = count_q;
    assign mem_ready = (free >= 4'd1);
    assign alu_ready = (free >= 4'd2) || ((free == 4'd1) && !mem_valid);

    // A handshake to r0 completes normally but does not allocate an entry.
    assign mem_push  = mem_valid && mem_ready && (mem_reg != 4'd0);
    assign alu_push  = alu_valid && alu_ready && (alu_reg != 4'd0);

    assign write_reg = !empty && !rf_stall;
    assign pop       = write_reg;
    assign dst_reg   = empty ? 4'd0  : reg_mem[head_q];
    assign dst_data  = empty ? 16'd0 : data_mem[head_q];

    // The ALU entry goes after the mem entry when both are pushed together.
    assign alu_wptr  = mem_push ? (tail_q + ptr_t'(1)) : tail_q;

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = pop ? (head_q + ptr_t'(1)) : head_q;
        tail_d  = tail_q + ptr_t'(mem_push) + ptr_t'(alu_push);
        count_d = count_q + 4'(mem_push) + 4'(alu_push) - 4'(pop);
    end

    // Pointer and count registers; reset discards all pending entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; validity is tracked by count, so storage has no reset.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            reg_mem[tail_q]  <= mem_reg;
            data_mem[tail_q] <= mem_data;
        end
        if (alu_push) begin
            reg_mem[alu_wptr]  <= alu_reg;
            data_mem[alu_wptr] <= alu_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan entries from oldest to youngest; the last match is the youngest.
    always_comb begin
        query_hit  = 1'b0;
        query_data = 16'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((4'(k) < count_q) && (query_reg != 4'd0) &&
                (reg_mem[head_q + ptr_t'(k)] == query_reg)) begin
                query_hit  = 1'b1;
                query_data = data_mem[head_q + ptr_t'(k)];
            end
        end
    end
`else
    // Pending-write detection across all occupied entries.
    always_comb begin
        query_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((4'(k) < count_q) && (query_reg != 4'd0) &&
                (reg_mem[head_q + ptr_t'(k)] == query_reg)) begin
                query_hit = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Testbench for wb_write_queue.
// A reference model tracks occupancy, and a scoreboard queue holds the
// expected writes in acceptance order.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_reg = 4'd0;
    logic [15:0] mem_data = 16'd0;
    logic        mem_ready;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_reg = 4'd0;
    logic [15:0] alu_data = 16'd0;
    logic        alu_ready;
    logic        rf_stall = 1'b0;
    logic        write_reg;
    logic [3:0]  dst_reg;
    logic [15:0] dst_data;
    logic [3:0]  query_reg = 4'd0;
    logic        query_hit;
    logic [3:0]  count;
    logic        full;
    logic        empty;
`ifdef WB_BYPASS_EN
    logic [15:0] query_data;
`endif

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    logic exp_mr, exp_ar, exp_wr;
    int   exp_cnt;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_stall(rf_stall), .write_reg(write_reg), .dst_reg(dst_reg), .dst_data(dst_data),
        .query_reg(query_reg), .query_hit(query_hit), .count(count), .full(full), .empty(empty)
`ifdef WB_BYPASS_EN
        , .query_data(query_data)
`endif
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus at the negedge and updates the model.
    // The exp_* values describe the DUT state before the next rising edge.
    task automatic cycle(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad,
                         input logic st);
        int free;
        @(negedge clk);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        rf_stall = st;
        free    = DEPTH - m_cnt;
        exp_cnt = m_cnt;
        exp_mr  = (free >= 1);
        exp_ar  = (free >= 2) || ((free == 1) && !mv);
        exp_wr  = (m_cnt > 0) && !st;
        if (exp_wr) m_cnt--;
        if (mv && exp_mr && (mr != 4'd0)) begin sb.push_back({mr, md}); m_cnt++; end
        if (av && exp_ar && (ar != 4'd0)) begin sb.push_back({ar, ad}); m_cnt++; end
        #1;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && write_reg) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", dst_reg, dst_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (dst_reg !== mon_e.r || dst_data !== mon_e.d) begin
                        failures++;
                        $display("FAIL write_order: got reg=%0d data=%h, required reg=%0d data=%h",
                                 dst_reg, dst_data, mon_e.r, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'h1234; query_reg = 4'd5;
        @(posedge clk); #1;
        checks++; if (count !== 4'd0)   begin failures++; $display("FAIL rst_count: got %0d required 0", count); end
        checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL rst_empty: got %0b required 1", empty); end
        checks++; if (full !== 1'b0)    begin failures++; $display("FAIL rst_full: got %0b required 0", full); end
        checks++; if (write_reg !== 1'b0) begin failures++; $display("FAIL rst_write: got %0b required 0", write_reg); end
        checks++; if (dst_reg !== 4'd0 || dst_data !== 16'd0)
            begin failures++; $display("FAIL rst_dst: got %0d/%h required 0/0000", dst_reg, dst_data); end
        checks++; if (query_hit !== 1'b0) begin failures++; $display("FAIL rst_query: got %0b required 0", query_hit); end
        @(negedge clk);
        mem_valid = 1'b0; query_reg = 4'd0; rst = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (mem_ready !== exp_mr) begin failures++; $display("FAIL single_ready: got %0b required %0b", mem_ready, exp_mr); end
        checks++; if (write_reg !== 1'b0)   begin failures++; $display("FAIL single_nowrite: got %0b required 0", write_reg); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (write_reg !== 1'b1)   begin failures++; $display("FAIL single_write: got %0b required 1", write_reg); end
        checks++; if (dst_reg !== 4'd5 || dst_data !== 16'h1234)
            begin failures++; $display("FAIL single_dst: got %0d/%h required 5/1234", dst_reg, dst_data); end
        checks++; if (count !== 4'd1)       begin failures++; $display("FAIL single_count1: got %0d required 1", count); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (count !== 4'd0 || empty !== 1'b1)
            begin failures++; $display("FAIL single_count0: got %0d/%0b required 0/1", count, empty); end
        checks++; if (dst_data !== 16'd0)   begin failures++; $display("FAIL single_empty_data: got %h required 0000", dst_data); end
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'(i), 16'h0100 + 16'(i), 1'b1);
            checks++; if (alu_ready !== exp_ar) begin failures++; $display("FAIL fill_alu_ready%0d: got %0b required %0b", i, alu_ready, exp_ar); end
        end
        cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd6, 16'h0666, 1'b1);
        checks++; if (full !== 1'b1)      begin failures++; $display("FAIL fill_full: got %0b required 1", full); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
            begin failures++; $display("FAIL fill_readies: got %0b/%0b required 0/0", mem_ready, alu_ready); end
        checks++; if (write_reg !== 1'b0) begin failures++; $display("FAIL fill_stalled: got %0b required 0", write_reg); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
            checks++; if (write_reg !== 1'b1 || count !== 4'(4 - i))
                begin failures++; $display("FAIL drain%0d: got wr=%0b cnt=%0d required 1/%0d", i, write_reg, count, 4 - i); end
        end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty: got %0b required 1", empty); end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'(8 + i), 16'h0800 + 16'(i), 1'b0, 4'd0, 16'd0, 1'b1);
        cycle(1'b1, 4'd11, 16'hB0B0, 1'b1, 4'd12, 16'hC0C0, 1'b1);
        checks++; if (count !== 4'd3)     begin failures++; $display("FAIL prio_count: got %0d required 3", count); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL prio_mem_ready: got %0b required 1", mem_ready); end
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL prio_alu_ready: got %0b required 0", alu_ready); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
            checks++; if (write_reg !== exp_wr) begin failures++; $display("FAIL prio_drain%0d: got %0b required %0b", i, write_reg, exp_wr); end
        end
        cycle(1'b1, 4'd13, 16'hD0D0, 1'b1, 4'd14, 16'hE0E0, 1'b0);
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
            begin failures++; $display("FAIL dual_ready: got %0b/%0b required 1/1", mem_ready, alu_ready); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (dst_reg !== 4'd13 || count !== 4'd2)
            begin failures++; $display("FAIL dual_first: got reg=%0d cnt=%0d required 13/2", dst_reg, count); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (dst_reg !== 4'd14) begin failures++; $display("FAIL dual_second: got %0d required 14", dst_reg); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic test_r0();
        cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %0b required 1", alu_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
            checks++; if (count !== 4'd0 || write_reg !== 1'b0)
                begin failures++; $display("FAIL r0_discard%0d: got cnt=%0d wr=%0b required 0/0", i, count, write_reg); end
        end
    endtask

    task automatic test_query();
        cycle(1'b1, 4'd7, 16'h0011, 1'b0, 4'd0, 16'd0, 1'b1);
        cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h0022, 1'b1);
        cycle(1'b1, 4'd3, 16'h0033, 1'b0, 4'd0, 16'd0, 1'b1);
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        query_reg = 4'd7; #1;
        checks++; if (query_hit !== 1'b1) begin failures++; $display("FAIL query7_hit: got %0b required 1", query_hit); end
`ifdef WB_BYPASS_EN
        checks++; if (query_data !== 16'h0022) begin failures++; $display("FAIL query7_data: got %h required 0022", query_data); end
`endif
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        query_reg = 4'd9; #1;
        checks++; if (query_hit !== 1'b0) begin failures++; $display("FAIL query9_hit: got %0b required 0", query_hit); end
`ifdef WB_BYPASS_EN
        checks++; if (query_data !== 16'h0000) begin failures++; $display("FAIL query9_data: got %h required 0000", query_data); end
`endif
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        query_reg = 4'd3; #1;
        checks++; if (query_hit !== 1'b1) begin failures++; $display("FAIL query3_hit: got %0b required 1", query_hit); end
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        query_reg = 4'd0; #1;
        checks++; if (query_hit !== 1'b0) begin failures++; $display("FAIL query0_hit: got %0b required 0", query_hit); end
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        query_reg = 4'd7; #1;
        checks++; if (query_hit !== 1'b0) begin failures++; $display("FAIL query_drained: got %0b required 0", query_hit); end
        query_reg = 4'd0;
    endtask

    task automatic test_back_to_back();
        logic mv, av, st;
        logic [3:0] mr, ar;
        for (int i = 0; i < 40; i++) begin
            mv = 1'($urandom_range(0, 1)); av = 1'($urandom_range(0, 1));
            mr = 4'($urandom_range(0, 15)); ar = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 3) == 0);
            cycle(mv, mr, 16'($urandom), av, ar, 16'($urandom), st);
            checks++; if (mem_ready !== exp_mr || alu_ready !== exp_ar)
                begin failures++; $display("FAIL stream_ready%0d: got %0b/%0b required %0b/%0b", i, mem_ready, alu_ready, exp_mr, exp_ar); end
            checks++; if (count !== 4'(exp_cnt) || write_reg !== exp_wr)
                begin failures++; $display("FAIL stream_state%0d: got cnt=%0d wr=%0b required %0d/%0b", i, count, write_reg, exp_cnt, exp_wr); end
        end
        for (int i = 0; i < 2 * DEPTH && m_cnt > 0; i++)
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        checks++; if (count !== 4'd0 || sb.size() != 0)
            begin failures++; $display("FAIL stream_drain: got cnt=%0d pending=%0d required 0/0", count, sb.size()); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'(1 + i), 16'hA000 + 16'(i), 1'b0, 4'd0, 16'd0, 1'b1);
        cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL mrst_pre: got %0d required 3", count); end
        #2; rst = 1'b0; #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1)
            begin failures++; $display("FAIL mrst_async: got cnt=%0d empty=%0b required 0/1", count, empty); end
        checks++; if (write_reg !== 1'b0) begin failures++; $display("FAIL mrst_write: got %0b required 0", write_reg); end
        rst = 1'b1;
        sb.delete();
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
            checks++; if (write_reg !== 1'b0 || count !== 4'd0)
                begin failures++; $display("FAIL mrst_after%0d: got wr=%0b cnt=%0d required 0/0", i, write_reg, count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_priority();
        test_r0();
        test_query();
        test_back_to_back();
        test_mid_reset();
        @(negedge clk);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL leftover: got %0d pending required 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..8).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge, except on reset.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port mem_valid, input, 1 bit: a load-writeback request is present.
REQ-005 Port mem_reg, input, 4 bits: destination register of the load writeback.
REQ-006 Port mem_data, input, 16 bits: data of the load writeback.
REQ-007 Port mem_ready, output, 1 bit: the load writeback is accepted this cycle.
REQ-008 Port alu_valid, input, 1 bit: an ALU-writeback request is present.
REQ-009 Port alu_reg, input, 4 bits: destination register of the ALU writeback.
REQ-010 Port alu_data, input, 16 bits: data of the ALU writeback.
REQ-011 Port alu_ready, output, 1 bit: the ALU writeback is accepted this cycle.
REQ-012 Port rf_stall, input, 1 bit: the register file cannot take a write this cycle.
REQ-013 Port write_reg, output, 1 bit: register-file write enable.
REQ-014 Port dst_reg, output, 4 bits: register-file write address.
REQ-015 Port dst_data, output, 16 bits: register-file write data.
REQ-016 Port query_reg, input, 4 bits: source register to check for a pending write.
REQ-017 Port query_hit, output, 1 bit: a queued write targets query_reg.
REQ-018 Port count, output, 4 bits: number of occupied entries.
REQ-019 Ports full and empty, output, 1 bit each: count==DEPTH and count==0 respectively.

Function
REQ-020 The block SHALL be a circular FIFO of {reg[3:0], data[15:0]} entries with head and tail pointers that wrap modulo DEPTH.
REQ-021 A handshake SHALL occur on a port in any cycle where its valid and ready are both 1; with free = DEPTH - count, mem_ready = (free >= 1).
REQ-022 alu_ready SHALL equal (free >= 2) OR (free == 1 AND NOT mem_valid), so mem has priority for the last slot.
REQ-023 When both ports handshake in one cycle, the block SHALL enqueue mem ahead of alu; the alu entry is therefore younger.
REQ-024 A handshake with reg == 0 SHALL be accepted and discarded: no entry is written and count is unchanged, since r0 is hardwired zero.
REQ-025 write_reg SHALL equal (NOT empty AND NOT rf_stall); dst_reg and dst_data SHALL come combinationally from the head entry.
REQ-026 The head SHALL be popped at the clock edge where write_reg = 1.
REQ-027 Latency: an entry enqueued at edge N into an empty queue SHALL drive write_reg = 1 during cycle N+1 (one cycle), unless rf_stall is high.
REQ-028 readiness SHALL NOT credit a same-cycle pop; push and pop in one cycle are both legal, and count updates by pushes minus pop.
REQ-029 When full, both readies SHALL be 0 and the head SHALL still drain.
REQ-030 When empty, write_reg SHALL be 0, and dst_reg and dst_data SHALL be 0.
REQ-031 query_hit SHALL be 1 iff query_reg != 0 and any occupied entry has reg == query_reg; it is combinational and does not include same-cycle inputs.
REQ-032 rf_stall SHALL only hold the head; it SHALL NOT affect enqueue.
REQ-033 No entry SHALL ever be lost or duplicated, and writes SHALL leave in acceptance order.

Reset
REQ-034 While rst = 0, head, tail and count SHALL be 0; outputs SHALL be count = 0, empty = 1, full = 0, write_reg = 0, dst_reg = 0, dst_data = 0, query_hit = 0.
REQ-035 An assertion of rst mid-operation SHALL discard all pending entries immediately, without a clock edge.
REQ-036 Entry storage need not be reset.

Configuration
REQ-037 When macro WB_BYPASS_EN is defined, the block SHALL add output query_data, 16 bits, carrying the data of the youngest occupied entry whose reg equals query_reg, or 0 when query_hit = 0.
REQ-038 When WB_BYPASS_EN is undefined, query_data SHALL be absent and query_hit behaviour SHALL be unchanged.

Verification
REQ-039 Reset, then a mem handshake with reg 5, data 0x1234: the next cycle SHALL show write_reg = 1, dst_reg = 5, dst_data = 0x1234, and count SHALL return to 0 after that.
REQ-040 Hold rf_stall = 1 and issue 4 ALU pushes (reg 1..4): full SHALL become 1 and alu_ready = 0; release the stall and writes SHALL occur on 4 consecutive cycles in order 1, 2, 3, 4.
REQ-041 With count = 3 (DEPTH 4), assert mem_valid and alu_valid together: mem SHALL be accepted and alu_ready SHALL be 0; at count = 0 both are accepted, mem written first.
REQ-042 Push alu reg 0, data 0xFFFF: alu_ready = 1, count SHALL stay 0, and write_reg SHALL never assert.
REQ-043 With WB_BYPASS_EN, queue reg 7 = 0x0011 and then reg 7 = 0x0022 under stall, and set query_reg = 7: query_hit SHALL be 1 and query_data SHALL be 0x0022.
REQ-044 With 3 entries queued, pulse rst low between edges: count SHALL be 0 and empty SHALL be 1 immediately, and no write SHALL follow.
